// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory data-port arbiter.
// Holds the FSM state encoding and the access length codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_RESP = 2'd2,
    ST_WR_RESP = 2'd3
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;
  localparam logic [1:0] LEN_R = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_extend.sv
// Load extension: picks byte/half/word from data and sign/zero-extends it.
// Ports: data (raw word), len (length code), uns (1 = zero-extend), ext (result).
module mem_port_arbiter_extend
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      len,
  input  logic            uns,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = '0;
    unique case (len)
      LEN_B:   ext = {{(XLEN-8){~uns & data[7]}}, data[7:0]};
      LEN_H:   ext = {{(XLEN-16){~uns & data[15]}}, data[15:0]};
      LEN_W:   ext = data;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory data port between m0 (LSU) and m1 (DMA) with round-robin
// grant, hides the 2-cycle read timing and returns a one-cycle response pulse.
// Ports: clk/rst; per requester valid/ready/we/addr/wdata/len/unsigned and
// rsp_valid/rsp_rdata/rsp_err; memory pins data_addr_r, data_r, data_w_en,
// data_addr_w, data_w, data_len_w.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [1:0]      m0_len,
  input  logic            m0_unsigned,
  output logic            m0_rsp_valid,
  output logic [XLEN-1:0] m0_rsp_rdata,
  output logic            m0_rsp_err,
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [1:0]      m1_len,
  input  logic            m1_unsigned,
  output logic            m1_rsp_valid,
  output logic [XLEN-1:0] m1_rsp_rdata,
  output logic            m1_rsp_err,
  output logic [XLEN-1:0] data_addr_r,
  input  logic [XLEN-1:0] data_r,
  output logic            data_w_en,
  output logic [XLEN-1:0] data_addr_w,
  output logic [XLEN-1:0] data_w,
  output logic [1:0]      data_len_w
);

  state_t state, state_nx;

  logic            last_grant;
  logic            owner;
  logic            err_q;
  logic            uns_q;
  logic [1:0]      len_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] ext;

  logic            can_grant, g0, g1, grant;
  logic            rd_grant, wr_grant, rsp_on;
  logic            w_we, w_uns;
  logic [1:0]      w_len;
  logic [XLEN-1:0] w_addr, w_wdata;

  // Gated by rst so no handshake is seen while reset is held.
  assign can_grant = !rst && (state != ST_RD_WAIT);
  // last_grant = 1 means m1 went last, so m0 wins a tie.
  assign g0 = can_grant && m0_valid && (!m1_valid || last_grant);
  assign g1 = can_grant && m1_valid && !g0;
  assign grant = g0 || g1;

  assign m0_ready = g0;
  assign m1_ready = g1;

  assign w_we    = g1 ? m1_we       : m0_we;
  assign w_uns   = g1 ? m1_unsigned : m0_unsigned;
  assign w_len   = g1 ? m1_len      : m0_len;
  assign w_addr  = g1 ? m1_addr     : m0_addr;
  assign w_wdata = g1 ? m1_wdata    : m0_wdata;

  assign rd_grant = grant && !w_we;
  assign wr_grant = grant && w_we;

  assign data_w_en   = wr_grant && (w_len != LEN_R);
  assign data_addr_w = wr_grant ? w_addr  : '0;
  assign data_w      = wr_grant ? w_wdata : '0;
  assign data_len_w  = wr_grant ? w_len   : '0;

  // Memory registers the address at the grant edge; hold it afterwards.
  assign data_addr_r = rd_grant ? w_addr : addr_q;

  assign rsp_on = (state == ST_RD_RESP) || (state == ST_WR_RESP);

  assign m0_rsp_valid = rsp_on && !owner;
  assign m1_rsp_valid = rsp_on && owner;
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_valid && err_q;
  assign m1_rsp_err   = m1_rsp_valid && err_q;

  mem_port_arbiter_extend #(.XLEN(XLEN)) u_ext (
    .data (data_r),
    .len  (len_q),
    .uns  (uns_q),
    .ext  (ext)
  );

  always_comb begin
    state_nx = ST_IDLE;
    unique case (state)
      ST_RD_WAIT: state_nx = ST_RD_RESP;
      default: begin
        if (grant) state_nx = w_we ? ST_WR_RESP : ST_RD_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      err_q      <= 1'b0;
      uns_q      <= 1'b0;
      len_q      <= LEN_B;
      addr_q     <= '0;
      rdata_q    <= '0;
    end else if (grant) begin
      last_grant <= g1;
      owner      <= g1;
      err_q      <= (w_len == LEN_R);
      uns_q      <= w_uns;
      len_q      <= w_len;
      rdata_q    <= '0;
      if (rd_grant) addr_q <= w_addr;
    end else if (state == ST_RD_WAIT) begin
      rdata_q <= err_q ? '0 : ext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 0, m0_we = 0, m0_unsigned = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic [1:0]  m0_len = 0;
  logic        m1_valid = 0, m1_we = 0, m1_unsigned = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic [1:0]  m1_len = 0;
  logic        m0_ready, m0_rsp_valid, m0_rsp_err;
  logic        m1_ready, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic [31:0] data_addr_r, data_addr_w, data_w;
  logic [31:0] data_r = 0;
  logic        data_w_en;
  logic [1:0]  data_len_w;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  mem_port_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_len(m0_len),
    .m0_unsigned(m0_unsigned), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_len(m1_len),
    .m1_unsigned(m1_unsigned), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .data_addr_r(data_addr_r), .data_r(data_r), .data_w_en(data_w_en),
    .data_addr_w(data_addr_w), .data_w(data_w), .data_len_w(data_len_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory model: byte array, little-endian, 32 bits read from any address.
  logic [7:0] mem [1024];
  logic [7:0] sh  [1024];

  function automatic int ix(logic [31:0] a);
    return int'(a & 32'h3FF);
  endfunction

  always @(posedge clk) begin
    data_r <= {mem[ix(data_addr_r+3)], mem[ix(data_addr_r+2)],
               mem[ix(data_addr_r+1)], mem[ix(data_addr_r)]};
    if (data_w_en) begin
      int n;
      n = (data_len_w == 2'd0) ? 1 : (data_len_w == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++)
        mem[ix(data_addr_w + i)] = data_w[8*i +: 8];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    else
      pass_cnt++;
  endtask

  // Reference load from the shadow memory, built from the length rules.
  function automatic logic [31:0] ref_load(logic [31:0] a,
                                           logic [1:0] len, bit uns);
    logic [31:0] v;
    v = 0;
    if (len == 2'd3) return 0;
    if (len == 2'd0) begin
      v = 32'(sh[ix(a)]);
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (len == 2'd1) begin
      v = 32'(sh[ix(a)]) + 32'(sh[ix(a+1)]) * 256;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      for (int i = 3; i >= 0; i--) v = v * 256 + 32'(sh[ix(a+i)]);
    end
    return v;
  endfunction

  // Transaction-level model: pending responses with due cycle and owner.
  typedef struct {
    int          due;
    bit          own;
    logic [31:0] rd;
    bit          err;
  } rsp_t;

  rsp_t rq[$];
  bit   lg = 1;
  bit   rd_busy = 0;

  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      lg = 1;
      rd_busy = 0;
      chk("rst_ctl", 64'({m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid,
          m0_rsp_err, m1_rsp_err, data_w_en, data_len_w}), 0);
      chk("rst_rdata", {m0_rsp_rdata, m1_rsp_rdata}, 0);
      chk("rst_addr", {data_addr_r, data_addr_w}, 0);
      chk("rst_wdata", 64'(data_w), 0);
    end else begin
      bit eg0, eg1, ev0, ev1, can, own, we, uns, ew;
      logic [31:0] ea, ewd, erd;
      logic [1:0] el;
      bit eerr;
      rsp_t r;
      can = !rd_busy;
      rd_busy = 0;
      eg0 = can && m0_valid && (!m1_valid || lg);
      eg1 = can && m1_valid && !eg0;
      chk("ready0", 64'(m0_ready), 64'(eg0));
      chk("ready1", 64'(m1_ready), 64'(eg1));
      ev0 = 0; ev1 = 0; erd = 0; eerr = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.own) ev1 = 1; else ev0 = 1;
        erd = r.rd;
        eerr = r.err;
      end
      chk("rsp_valid0", 64'(m0_rsp_valid), 64'(ev0));
      chk("rsp_valid1", 64'(m1_rsp_valid), 64'(ev1));
      chk("rsp_rdata0", 64'(m0_rsp_rdata), 64'(ev0 ? erd : 32'd0));
      chk("rsp_rdata1", 64'(m1_rsp_rdata), 64'(ev1 ? erd : 32'd0));
      chk("rsp_err0", 64'(m0_rsp_err), 64'(ev0 && eerr));
      chk("rsp_err1", 64'(m1_rsp_err), 64'(ev1 && eerr));
      ew = 0;
      if (eg0 || eg1) begin
        own = eg1;
        lg  = eg1;
        we  = own ? m1_we : m0_we;
        ea  = own ? m1_addr : m0_addr;
        ewd = own ? m1_wdata : m0_wdata;
        el  = own ? m1_len : m0_len;
        uns = own ? m1_unsigned : m0_unsigned;
        if (we) begin
          if (el != 2'd3) begin
            ew = 1;
            for (int i = 0; i < (el == 0 ? 1 : el == 1 ? 2 : 4); i++)
              sh[ix(ea + i)] = ewd[8*i +: 8];
            chk("w_addr", 64'(data_addr_w), 64'(ea));
            chk("w_data", 64'(data_w), 64'(ewd));
            chk("w_len", 64'(data_len_w), 64'(el));
          end
          rq.push_back('{cyc + 1, own, 32'd0, el == 2'd3});
        end else begin
          chk("r_addr", 64'(data_addr_r), 64'(ea));
          rq.push_back('{cyc + 2, own, ref_load(ea, el, uns), el == 2'd3});
          rd_busy = 1;
        end
      end
      chk("w_en", 64'(data_w_en), 64'(ew));
    end
  end

  task automatic set_req(bit p, bit we, logic [31:0] a, logic [31:0] wd,
                         logic [1:0] len, bit uns);
    if (!p) begin
      m0_valid = 1; m0_we = we; m0_addr = a; m0_wdata = wd;
      m0_len = len; m0_unsigned = uns;
    end else begin
      m1_valid = 1; m1_we = we; m1_addr = a; m1_wdata = wd;
      m1_len = len; m1_unsigned = uns;
    end
  endtask

  task automatic do_txn(bit p, bit we, logic [31:0] a, logic [31:0] wd,
                        logic [1:0] len, bit uns, output logic [31:0] rd,
                        output bit err, output int lat);
    int acc;
    bit ok;
    rd = 32'hBAD0BAD0; err = 0; lat = -1; acc = 0;
    @(posedge clk); #1;
    set_req(p, we, a, wd, len, uns);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((p ? m1_ready : m0_ready) === 1'b1) begin ok = 1; acc = cyc; end
    end
    @(posedge clk); #1;
    m0_valid = 0; m1_valid = 0;
    if (!ok) begin chk("txn_accept_timeout", 0, 1); return; end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((p ? m1_rsp_valid : m0_rsp_valid) === 1'b1) begin
        ok = 1;
        rd = p ? m1_rsp_rdata : m0_rsp_rdata;
        err = p ? m1_rsp_err : m0_rsp_err;
        lat = cyc - acc;
      end
    end
    if (!ok) chk("txn_rsp_timeout", 0, 1);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    bit          uns;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tv[13];

  initial begin
    logic [31:0] rd;
    bit err;
    int lat, n, pulses;
    int got[6];
    bit ok;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'(i) ^ 8'hA5;
      sh[i]  = 8'(i) ^ 8'hA5;
    end

    tv[0]  = '{0, 1, 32'h100, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0, 1};
    tv[1]  = '{0, 0, 32'h100, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0, 2};
    tv[2]  = '{0, 0, 32'h103, 32'h0, 2'd0, 0, 32'hFFFFFFDE, 0, 2};
    tv[3]  = '{0, 0, 32'h103, 32'h0, 2'd0, 1, 32'h000000DE, 0, 2};
    tv[4]  = '{0, 0, 32'h100, 32'h0, 2'd1, 0, 32'hFFFFBEEF, 0, 2};
    tv[5]  = '{1, 0, 32'h100, 32'h0, 2'd1, 1, 32'h0000BEEF, 0, 2};
    tv[6]  = '{0, 1, 32'h200, 32'h55, 2'd3, 0, 32'h0, 1, 1};
    tv[7]  = '{1, 0, 32'h200, 32'h0, 2'd2, 0, 32'hA6A7A4A5, 0, 2};
    tv[8]  = '{1, 1, 32'h204, 32'h80, 2'd0, 0, 32'h0, 0, 1};
    tv[9]  = '{0, 0, 32'h204, 32'h0, 2'd0, 0, 32'hFFFFFF80, 0, 2};
    tv[10] = '{0, 0, 32'h204, 32'h0, 2'd3, 0, 32'h0, 1, 2};
    tv[11] = '{1, 1, 32'h208, 32'hFFFF8001, 2'd1, 0, 32'h0, 0, 1};
    tv[12] = '{1, 0, 32'h208, 32'h0, 2'd1, 1, 32'h00008001, 0, 2};

    repeat (3) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 13; i++) begin
      do_txn(tv[i].port, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].len,
             tv[i].uns, rd, err, lat);
      chk($sformatf("tv%0d_rdata", i), 64'(rd), 64'(tv[i].exp_rdata));
      chk($sformatf("tv%0d_err", i), 64'(err), 64'(tv[i].exp_err));
      chk($sformatf("tv%0d_lat", i), 64'(lat), 64'(tv[i].exp_lat));
    end

    // Alternating grants with both requesters always valid.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    set_req(0, 0, 32'h100, 0, 2'd2, 0);
    set_req(1, 0, 32'h104, 0, 2'd2, 1);
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      @(negedge clk);
      if (m0_ready) begin got[n] = 0; n++; end
      else if (m1_ready) begin got[n] = 1; n++; end
    end
    chk("alt_count", 64'(n), 6);
    for (int i = 0; i < n; i++)
      chk($sformatf("alt_grant%0d", i), 64'(got[i]), 64'(i % 2));
    @(posedge clk); #1 m0_valid = 0; m1_valid = 0;
    repeat (4) @(posedge clk);

    // Reset while a read sits in RD_WAIT.
    #1 set_req(0, 0, 32'h100, 0, 2'd2, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (m0_ready) ok = 1;
    end
    chk("rstw_accept", 64'(ok), 1);
    @(posedge clk); #1 m0_valid = 0; rst = 1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_rsp_valid || m1_rsp_valid) pulses++;
    end
    @(posedge clk); #1 rst = 0;
    set_req(0, 0, 32'h104, 0, 2'd2, 0);
    @(negedge clk);
    if (m0_rsp_valid || m1_rsp_valid) pulses++;
    chk("rstw_no_rsp", 64'(pulses), 0);
    chk("rstw_ready_after", 64'(m0_ready), 1);
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_rsp_valid", 64'(m0_rsp_valid), 1);
    chk("rstw_rsp_rdata", 64'(m0_rsp_rdata), 64'(ref_load(32'h104, 2'd2, 0)));
    repeat (2) @(posedge clk);

    // Write then read of the same address with no idle cycle between.
    #1 set_req(0, 1, 32'h300, 32'h12345678, 2'd2, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (m0_ready) ok = 1;
    end
    chk("b2b_wr_accept", 64'(ok), 1);
    @(posedge clk); #1 m0_valid = 0;
    set_req(1, 0, 32'h300, 0, 2'd2, 0);
    @(negedge clk);
    chk("b2b_rd_ready", 64'(m1_ready), 1);
    chk("b2b_wr_rsp", 64'(m0_rsp_valid), 1);
    @(posedge clk); #1 m1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_rsp_valid", 64'(m1_rsp_valid), 1);
    chk("b2b_rsp_rdata", 64'(m1_rsp_rdata), 64'h12345678);
    repeat (2) @(posedge clk);

    // Random traffic, checked every cycle by the reference model.
    for (int i = 0; i < 3000; i++) begin
      #1;
      m0_valid = 1'($urandom_range(0, 1));
      m0_we = 1'($urandom_range(0, 1));
      m0_addr = 32'($urandom_range(0, 1023));
      m0_wdata = $urandom;
      m0_len = 2'($urandom_range(0, 3));
      m0_unsigned = 1'($urandom_range(0, 1));
      m1_valid = 1'($urandom_range(0, 1));
      m1_we = 1'($urandom_range(0, 1));
      m1_addr = 32'($urandom_range(0, 1023));
      m1_wdata = $urandom;
      m1_len = 2'($urandom_range(0, 3));
      m1_unsigned = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1 m0_valid = 0; m1_valid = 0;
    repeat (5) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous data port of the unified memory between two requesters: m0 (core load/store unit) and m1 (DMA/loader).
- Owns the memory's 2-cycle read timing, so requesters see a simple valid/ready request plus a one-cycle response pulse.
- Sign/zero-extends byte and half loads.
- Sits between the LSU/DMA and the memory's data_addr_r/data_r/data_w_en/data_addr_w/data_w/data_len_w pins.

Parameters:
XLEN, 32, address/data width (matches `XLEN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mX_valid  in  1  request valid (X = 0, 1; same set per requester)
mX_ready  out  1  request accepted this cycle (combinational)
mX_we  in  1  1 = write, 0 = read
mX_addr  in  XLEN  byte address
mX_wdata  in  XLEN  write data, LSB-aligned
mX_len  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
mX_unsigned  in  1  read: zero-extend when 1, sign-extend when 0
mX_rsp_valid  out  1  one-cycle response pulse
mX_rsp_rdata  out  XLEN  extended read data; 0 for writes and errors
mX_rsp_err  out  1  asserted with rsp_valid when len == 3
data_addr_r  out  XLEN  memory read address
data_r  in  XLEN  memory read data, registered by memory, 32 bits from data_addr_r
data_w_en  out  1  memory write enable
data_addr_w  out  XLEN  memory write address
data_w  out  XLEN  memory write data
data_len_w  out  2  memory write length

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high.
  - state=IDLE, last_grant=1 (m0 wins first).
  - All mX_ready, mX_rsp_valid, mX_rsp_err and data_w_en are 0.
  - mX_rsp_rdata, data_addr_r, data_addr_w, data_w and data_len_w are 0.
- States: IDLE, RD_WAIT, RD_RESP, WR_RESP. One transaction outstanding at a time.
- Grant:
  - Allowed only in IDLE, RD_RESP or WR_RESP, so back-to-back transactions run with no bubble.
  - Exactly one of mX_ready may be high.
  - If both requesters are valid, the one not in last_grant wins; last_grant updates on each grant.
- Write (accepted at cycle T):
  - In cycle T, data_w_en=1 and data_addr_w/data_w/data_len_w are driven combinationally from the winner; memory commits at the end of T.
  - Cycle T+1 is WR_RESP: rsp_valid=1, rdata=0.
- Read (accepted at cycle T):
  - In cycle T, data_addr_r = winner's addr.
  - T+1 is RD_WAIT: data_addr_r held from a registered copy; data_r is valid and is captured after extension.
  - T+2 is RD_RESP: rsp_valid=1 to the owner. Latency from accept to response is 2 cycles.
- Extension: len 0 uses data_r[7:0]; len 1 uses data_r[15:0]; len 2 uses the full word. Upper bits are data_r's top selected bit when unsigned=0, otherwise 0.
- Reserved len (3):
  - Accepted normally, but data_w_en stays 0.
  - The response comes at the normal latency with err=1 and rdata=0.
- Outside grant/RD_WAIT cycles: data_w_en=0 and data_addr_r holds its last value.
- Response is not backpressured: rsp_valid is a single-cycle pulse, and the requester must sample it.
- RAW ordering: a read accepted in the cycle after a write to the same address returns the new data.
- Reset mid-transaction: the state returns to IDLE immediately and no response is issued for the aborted request.
- mX_ready never asserts while in RD_WAIT.

Decomposition:
- Shared package/header holds:
  - State encoding constants ST_IDLE/ST_RD_WAIT/ST_RD_RESP/ST_WR_RESP.
  - Length codes LEN_B=0, LEN_H=1, LEN_W=2.
- One natural sub-module, load_extend: combinational data_r, len, unsigned -> extended word.

Test Plan:
- m0 write word 0x100 = 0xDEADBEEF, then m0 read lw 0x100 -> data_w_en one cycle; read rsp 2 cycles after accept, rdata=0xDEADBEEF.
- Byte load sign/zero: m0 lb 0x103 -> 0xFFFFFFDE; m0 lbu 0x103 -> 0x000000DE; lh 0x100 -> 0xFFFFBEEF.
- Both valid every cycle, reads only -> grants alternate m0, m1, m0 starting with m0 after reset; each response reaches only its owner.
- len=3 write of 0x55 to 0x200 -> no data_w_en; rsp_err=1 next cycle; a later lw 0x200 returns the prior content.
- rst asserted in RD_WAIT -> no rsp_valid; state IDLE; next request accepted in the cycle after rst deasserts.
- Back-to-back m0 write 0x300 = 0x12345678 then m1 read 0x300 in the next cycle -> m1 rdata=0x12345678, no idle cycle between grants.
